dct_mac_scheduler: RTL and testbench
====================================

Name: dct_mac_scheduler

Overview:
- Sequences one 8x8 2D DCT over a pixel block held in an external synchronous-read pixel RAM.
- For each coefficient (k1,k2), in row-major order, it sweeps all 64 (n1,n2) positions. It drives the pixel address and the selects for the cos-term LUT bank, multiply-accumulates pixel x cos_term, and then presents the scaled coefficient on a valid/ready output.
- It sits between the frame buffer and the coefficient quantiser/encoder in the DCT pipeline.

Parameters:
- PIX_W, 8, unsigned pixel width.
- ACC_W, 40, signed accumulator width.
- OUT_SHIFT, 8, arithmetic right shift removing the LUT fixed-point scale.
- COEF_W, 16, signed output coefficient width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begin a block transform (ignored unless IDLE)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the 64th coefficient handshake
- pix_addr  out  6  {n1,n2} pixel RAM read address
- pix_rdata  in  PIX_W  pixel RAM data, valid one cycle after pix_addr
- lut_k1, lut_k2  out  3 each  frequency select to the cos LUT bank
- lut_n1, lut_n2  out  3 each  spatial select to the LUT (pix_addr delayed 1 cycle)
- cos_term  in  32  signed combinational LUT output
- coef_valid  out  1  coefficient available
- coef_ready  in  1  downstream accepts
- coef_data  out  COEF_W  signed coefficient
- coef_idx  out  6  {k1,k2} of coef_data

Behaviour:
- **Clock and reset**
  - One clock domain; reset is synchronous and active-high.
  - While reset is high, all outputs are 0, the FSM goes to IDLE, and the accumulator and all counters are cleared.
  - Reset asserted mid-operation aborts the block immediately. No done pulse is produced and no partial coefficient is emitted.
- **FSM states:** IDLE, ISSUE, DRAIN, OUT.
  - IDLE -> ISSUE on start. k counter is set to 0 and busy goes to 1.
  - ISSUE
    - Lasts 64 cycles.
    - pix_addr steps 0..63, with n1 = pix_addr[5:3] and n2 = pix_addr[2:0].
    - lut_n1/lut_n2 carry the previous cycle's pix_addr, so cos_term aligns with pix_rdata.
    - The accumulator clears on the first ISSUE cycle of each coefficient.
    - Accumulation (acc += signed(pixel) * cos_term) occurs in the cycles after ISSUE cycles 0..63. The last accumulation falls in DRAIN.
  - ISSUE -> DRAIN after address 63.
  - DRAIN (1 cycle): performs the final accumulate. DRAIN -> OUT.
  - OUT
    - coef_valid = 1.
    - coef_data = sat_COEF_W(acc >>> OUT_SHIFT), using an arithmetic (floor) shift and saturation to [-2^(COEF_W-1), 2^(COEF_W-1)-1].
    - coef_idx = k.
    - coef_data, coef_idx and coef_valid are held stable while coef_ready = 0.
    - On coef_valid & coef_ready:
      - if k = 63: done pulses for 1 cycle, busy drops, return to IDLE;
      - else: k increments and the FSM goes to ISSUE.
- **LUT selects:** lut_k1 = k[5:3] and lut_k2 = k[2:0], held constant for a whole coefficient.
- **Throughput:** 66 cycles per coefficient with coef_ready tied high, giving 4224 cycles from start to done.
- **Idle outputs:** pix_addr and all LUT selects are 0 in IDLE.
- **Start handling:** start while busy is ignored (no restart, no queuing).
- **Arithmetic:** the product is a PIX_W+1 bit signed pixel times a 32-bit signed cos_term, sign-extended to ACC_W. ACC_W = 40 cannot overflow for 64 terms of the LUT's range.

Optional Feature:
- Macro: DCT_LEVEL_SHIFT_EN.
- Defined: the pixel is level-shifted before multiplication (signed(pixel) = pix_rdata - 2^(PIX_W-1)), giving range -128..127 for PIX_W = 8.
- Undefined: pixel is zero-extended unchanged.
- Handshake and timing are identical in both builds.

Test Plan:
1. All pixels 0, macro off, coef_ready=1, start pulse -> 64 coefficients all 0, coef_idx 0..63 in order; done pulses at cycle 4224 after start; busy low the cycle after.
2. Pixel (n1=0,n2=1)=100, others 0, macro off -> coef_idx 14 (k1=1,k2=6) gives 100*(-0xE7) = -23100, >>>8 = -91; coef_idx 0 matches the reference-model LUT value.
3. All pixels 1, macro off -> coef_idx 14 = 0, since the k1=1,k2=6 cos terms sum to zero.
4. coef_ready held low 10 cycles during coefficient 5 -> coef_valid stays 1 and coef_data/coef_idx stay unchanged; no pix_addr activity; sequence resumes on the ready cycle; done is delayed by exactly 10 cycles.
5. Reset asserted during ISSUE of coefficient 20 -> next cycle all outputs 0, FSM in IDLE, no done pulse; a following start produces coefficient 0 first.
6. start re-pulsed while busy; macro on with all pixels 128 -> no restart; all coefficients 0.

Source files
------------

// File: rtl/dct_mac_scheduler_if.sv
// -----------------------------------------------------------------------------
// dct_mac_scheduler_if
//   Bundles every non-clock signal of the DCT MAC scheduler.
//
//   master modport : the scheduler itself
//     out: busy, done, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
//          coef_valid, coef_data, coef_idx
//     in : start, pix_rdata, cos_term, coef_ready
//   slave modport  : the surrounding pipeline (frame buffer, LUT bank,
//                    quantiser/encoder); the same signals, opposite direction
// -----------------------------------------------------------------------------
interface dct_mac_scheduler_if #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [5:0]               pix_addr;
    logic [PIX_W-1:0]         pix_rdata;
    logic [2:0]               lut_k1;
    logic [2:0]               lut_k2;
    logic [2:0]               lut_n1;
    logic [2:0]               lut_n2;
    logic signed [31:0]       cos_term;
    logic                     coef_valid;
    logic                     coef_ready;
    logic signed [COEF_W-1:0] coef_data;
    logic [5:0]               coef_idx;

    modport master (
        input  start, pix_rdata, cos_term, coef_ready,
        output busy, done, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
               coef_valid, coef_data, coef_idx
    );

    modport slave (
        output start, pix_rdata, cos_term, coef_ready,
        input  busy, done, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
               coef_valid, coef_data, coef_idx
    );
endinterface

// File: rtl/dct_mac_scheduler.sv
// -----------------------------------------------------------------------------
// dct_mac_scheduler
//   Sequences one 8x8 2D DCT over a pixel block held in an external
//   synchronous-read RAM. For each coefficient k = {k1,k2} (row-major) it
//   sweeps all 64 pixel positions, multiply-accumulates pixel x cos_term and
//   presents the scaled, saturated coefficient on a valid/ready output.
//   66 cycles per coefficient with coef_ready high: 64 ISSUE, 1 DRAIN, 1 OUT.
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high reset (aborts any block in flight)
//   bus    : dct_mac_scheduler_if.master
//            start/busy/done       block control
//            pix_addr/pix_rdata    pixel RAM ({n1,n2}; data one cycle later)
//            lut_k*/lut_n*         cos LUT selects; cos_term is the LUT output
//            coef_valid/ready/data/idx  coefficient output handshake
//
// Build option
//   DCT_LEVEL_SHIFT_EN : when defined, pixels are level-shifted by
//                        -2^(PIX_W-1) before multiplication; otherwise they
//                        are zero-extended unchanged.
// -----------------------------------------------------------------------------
module dct_mac_scheduler #(
    parameter int PIX_W     = 8,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 8,
    parameter int COEF_W    = 16
) (
    input logic                 clk,
    input logic                 reset,
    dct_mac_scheduler_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int PROD_W = PIX_W + 1 + 32;

    // Saturation bounds of a COEF_W signed value, expressed at ACC_W width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};

    logic [1:0]               state;
    logic [5:0]               k;        // current coefficient {k1,k2}
    logic [5:0]               addr;     // pixel address being issued
    logic [5:0]               addr_d;   // address whose data arrives this cycle
    logic                     mac_en;   // previous cycle was an ISSUE cycle
    logic                     done_q;
    logic signed [ACC_W-1:0]  acc;

    logic signed [PIX_W:0]    pixel;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [COEF_W-1:0] sat;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
`ifdef DCT_LEVEL_SHIFT_EN
    assign pixel = $signed({1'b0, bus.pix_rdata}) - $signed({2'b01, {(PIX_W-1){1'b0}}});
`else
    assign pixel = $signed({1'b0, bus.pix_rdata});
`endif

    assign product = PROD_W'(pixel) * PROD_W'(bus.cos_term);
    assign term    = ACC_W'(product);
    assign shifted = acc >>> OUT_SHIFT;   // floor division by 2^OUT_SHIFT

    // NOTE: every branch assigns sat, so this stays pure combinational logic;
    // a missing else would infer a latch.
    always_comb begin
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[COEF_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[COEF_W-1:0];
        end else begin
            sat = shifted[COEF_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and accumulator
    // -------------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; the later acc clear in ISSUE deliberately
    // overrides the generic accumulate above it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            addr   <= '0;
            addr_d <= '0;
            mac_en <= 1'b0;
            done_q <= 1'b0;
            acc    <= '0;
        end else begin
            done_q <= 1'b0;
            addr_d <= addr;
            mac_en <= (state == ISSUE);

            // Data for an address issued last cycle is on pix_rdata now.
            if (mac_en) begin
                acc <= acc + term;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k     <= '0;
                        addr  <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // First ISSUE cycle of a coefficient: nothing is in
                    // flight yet, so clearing here loses no product.
                    if (addr == 6'd0) begin
                        acc <= '0;
                    end
                    addr <= addr + 6'd1;   // wraps to 0 after 63
                    if (addr == 6'd63) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    if (bus.coef_ready) begin
                        if (k == 6'd63) begin
                            k      <= '0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            k     <= k + 6'd1;
                            state <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all derived from registers, so they are 0 the cycle after reset)
    // -------------------------------------------------------------------------
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.pix_addr   = addr;
    assign bus.lut_k1     = k[5:3];
    assign bus.lut_k2     = k[2:0];
    assign bus.lut_n1     = addr_d[5:3];
    assign bus.lut_n2     = addr_d[2:0];
    assign bus.coef_valid = (state == OUT);
    assign bus.coef_data  = (state == OUT) ? sat : '0;
    assign bus.coef_idx   = (state == OUT) ? k : '0;

endmodule

// File: tb/tb_dct_mac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dct_mac_scheduler
//   Directed bench for dct_mac_scheduler. Provides a synchronous-read pixel
//   RAM and a cos LUT built from truncated 1D terms:
//     T(k,n)   = trunc(256*cos((2n+1)k*pi/16))
//     cos_term = trunc(T(k1,n1)*T(k2,n2)/256)
//   Cycle numbering: cycle 0 is the first cycle after the clock edge that
//   accepts start.
// -----------------------------------------------------------------------------
module tb_dct_mac_scheduler;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 16;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam int  BASE      = 128;  // pixel value that level-shifts to 0
    localparam logic signed [15:0] FLAT128_DC = 16'sd0;
`else
    localparam int  BASE      = 0;
    localparam logic signed [15:0] FLAT128_DC = 16'sd8192;  // 64*128*256 >>> 8
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    dct_mac_scheduler_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

    dct_mac_scheduler #(
        .PIX_W(PIX_W), .ACC_W(40), .OUT_SHIFT(8), .COEF_W(COEF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ models
    logic [7:0] ram [64];
    int         lut_force = 0;   // 0: real LUT, 1: +2^20, 2: -2^20

    always @(posedge clk) bus.pix_rdata <= ram[bus.pix_addr];

    function automatic int mag(input int m);
        case (m)
            0: return 256;
            1: return 251;
            2: return 236;
            3: return 212;
            4: return 181;
            5: return 142;
            6: return 97;
            7: return 49;
            default: return 0;
        endcase
    endfunction

    function automatic int cos1d(input int k, input int n);
        int a;
        a = ((2 * n + 1) * k) % 32;
        if (a > 16) a = 32 - a;
        if (a > 8) return -mag(16 - a);
        return mag(a);
    endfunction

    always_comb begin
        if (lut_force == 1) begin
            bus.cos_term = 32'sd1048576;
        end else if (lut_force == 2) begin
            bus.cos_term = -32'sd1048576;
        end else begin
            bus.cos_term = (cos1d(int'(bus.lut_k1), int'(bus.lut_n1)) *
                            cos1d(int'(bus.lut_k2), int'(bus.lut_n2))) / 256;
        end
    end

    // --------------------------------------------------------------- bookkeeping
    int checks   = 0;
    int failures = 0;

    logic signed [15:0] cap_data [64];
    logic [5:0]         cap_idx  [64];
    int                 cap_count;
    int                 done_cycle;
    int                 done_count;
    int                 stall_bad;
    bit                 timeout;
    logic               busy_first;
    logic               busy_after;
    logic [5:0]         probe_addr5;
    logic [5:0]         probe_lutn6;
    logic [5:0]         probe_lutk;

    task automatic fill(input int v);
        for (int i = 0; i < 64; i++) ram[i] = 8'(v);
    endtask

    // Starts one block and follows it to completion, capturing every
    // coefficient handshake. Optionally stalls one coefficient and re-pulses
    // start while busy.
    task automatic run_block(input int stall_coef, input int stall_len, input bit restart);
        int                 c;
        int                 stall_left;
        bit                 holding;
        logic signed [15:0] held_d;
        logic [5:0]         held_i;
        cap_count  = 0;
        done_cycle = -1;
        done_count = 0;
        stall_bad  = 0;
        timeout    = 0;
        busy_after = 1'b1;
        holding    = 0;
        held_d     = '0;
        held_i     = '0;
        stall_left = stall_len;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        c          = 0;
        busy_first = bus.busy;
        while (1) begin
            if (c == 5) probe_addr5 = bus.pix_addr;
            if (c == 6) probe_lutn6 = {bus.lut_n1, bus.lut_n2};
            if (c == 66 * 14 + 3) probe_lutk = {bus.lut_k1, bus.lut_k2};
            if (bus.done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0 && c == done_cycle + 1) begin
                busy_after = bus.busy;
                break;
            end
            if (c >= 6000) begin
                timeout = 1;
                break;
            end
            bus.start      = restart && (c == 100 || c == 3000);
            bus.coef_ready = 1'b1;
            if (bus.coef_valid && int'(bus.coef_idx) == stall_coef) begin
                if (holding) begin
                    if (bus.coef_data !== held_d || bus.coef_idx !== held_i ||
                        bus.pix_addr !== 6'd0 || {bus.lut_n1, bus.lut_n2} !== 6'd0)
                        stall_bad++;
                end else begin
                    held_d  = bus.coef_data;
                    held_i  = bus.coef_idx;
                    holding = 1;
                end
                if (stall_left > 0) begin
                    bus.coef_ready = 1'b0;
                    stall_left--;
                end
            end
            if (bus.coef_valid && bus.coef_ready && cap_count < 64) begin
                cap_data[cap_count] = bus.coef_data;
                cap_idx[cap_count]  = bus.coef_idx;
                cap_count++;
            end
            @(negedge clk);
            c++;
        end
        bus.start      = 1'b0;
        bus.coef_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.pix_addr, bus.lut_k1, bus.lut_k2, bus.lut_n1,
             bus.lut_n2, bus.coef_valid, bus.coef_data, bus.coef_idx} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%0d valid=%b data=%0d idx=%0d, want all 0",
                     bus.busy, bus.done, bus.pix_addr, bus.coef_valid, bus.coef_data, bus.coef_idx);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_zero_block();
        int bad_idx;
        int bad_data;
        fill(BASE);
        run_block(-1, 0, 0);
        bad_idx  = 0;
        bad_data = 0;
        for (int i = 0; i < 64; i++) begin
            if (cap_idx[i] !== 6'(i)) bad_idx++;
            if (cap_data[i] !== 16'sd0) bad_data++;
        end
        checks++;
        if (timeout || cap_count !== 64) begin
            failures++;
            $display("FAIL zero_count: got %0d coefficients (timeout=%0d), want 64", cap_count, timeout);
        end
        checks++;
        if (bad_idx !== 0) begin
            failures++;
            $display("FAIL zero_idx_order: %0d out-of-order indices, want 0", bad_idx);
        end
        checks++;
        if (bad_data !== 0) begin
            failures++;
            $display("FAIL zero_data: %0d nonzero coefficients, want 0", bad_data);
        end
        checks++;
        if (done_cycle !== 4224 || done_count !== 1) begin
            failures++;
            $display("FAIL zero_done: cycle=%0d count=%0d, want cycle 4224 count 1", done_cycle, done_count);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy: first=%b after_done=%b, want 1 and 0", busy_first, busy_after);
        end
        checks++;
        if (probe_addr5 !== 6'd5 || probe_lutn6 !== 6'd5) begin
            failures++;
            $display("FAIL zero_addr_align: addr@5=%0d lut_n@6=%0d, want 5 and 5", probe_addr5, probe_lutn6);
        end
        checks++;
        if (probe_lutk !== 6'd14) begin
            failures++;
            $display("FAIL zero_lut_k: got %0d, want 14 during coefficient 14", probe_lutk);
        end
    endtask

    task automatic test_single_pixel();
        fill(BASE);
        ram[1] = 8'(BASE + 100);
        run_block(-1, 0, 0);
        checks++;
        if (cap_data[0] !== 16'sd100) begin      // 100*256 >>> 8
            failures++;
            $display("FAIL single_dc: got %0d, want 100", cap_data[0]);
        end
        checks++;
        if (cap_data[1] !== 16'sd82) begin       // 100*212 >>> 8
            failures++;
            $display("FAIL single_k01: got %0d, want 82", cap_data[1]);
        end
        checks++;
        if (cap_data[8] !== 16'sd98) begin       // 100*251 >>> 8
            failures++;
            $display("FAIL single_k10: got %0d, want 98", cap_data[8]);
        end
        checks++;
        if (cap_data[14] !== -16'sd91 || cap_idx[14] !== 6'd14) begin  // -23100 >>> 8
            failures++;
            $display("FAIL single_k16: got %0d idx %0d, want -91 idx 14", cap_data[14], cap_idx[14]);
        end
    endtask

    task automatic test_ones();
        fill(BASE + 1);
        run_block(-1, 0, 0);
        checks++;
        if (cap_data[14] !== 16'sd0) begin
            failures++;
            $display("FAIL ones_k16: got %0d, want 0", cap_data[14]);
        end
        checks++;
        if (cap_data[0] !== 16'sd64 || cap_data[1] !== 16'sd0) begin
            failures++;
            $display("FAIL ones_dc: got dc=%0d k01=%0d, want 64 and 0", cap_data[0], cap_data[1]);
        end
    endtask

    task automatic test_back_to_back_stall();
        int bad_idx;
        fill(BASE);
        ram[1] = 8'(BASE + 100);
        run_block(5, 10, 0);
        bad_idx = 0;
        for (int i = 0; i < 64; i++) if (cap_idx[i] !== 6'(i)) bad_idx++;
        checks++;
        if (stall_bad !== 0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable stall cycles, want 0", stall_bad);
        end
        checks++;
        if (cap_data[5] !== -16'sd99) begin      // 100*-251 >>> 8
            failures++;
            $display("FAIL stall_k05: got %0d, want -99", cap_data[5]);
        end
        checks++;
        if (done_cycle !== 4234 || bad_idx !== 0 || cap_count !== 64) begin
            failures++;
            $display("FAIL stall_done: cycle=%0d bad_idx=%0d count=%0d, want 4234 0 64",
                     done_cycle, bad_idx, cap_count);
        end
    endtask

    task automatic test_reset_abort();
        int c;
        int bad;
        fill(BASE);
        ram[1] = 8'(BASE + 100);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (c < 66 * 20 + 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.pix_addr !== 6'd10 || {bus.lut_k1, bus.lut_k2} !== 6'd20) begin
            failures++;
            $display("FAIL abort_pre: busy=%b addr=%0d k=%0d, want 1 10 20",
                     bus.busy, bus.pix_addr, {bus.lut_k1, bus.lut_k2});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.pix_addr, bus.lut_k1, bus.lut_k2, bus.lut_n1,
             bus.lut_n2, bus.coef_valid, bus.coef_data, bus.coef_idx} !== 43'd0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b addr=%0d valid=%b data=%0d, want all 0",
                     bus.busy, bus.pix_addr, bus.coef_valid, bus.coef_data);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.coef_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d cycles with done/valid/busy, want 0", bad);
        end
        run_block(-1, 0, 0);
        checks++;
        if (cap_idx[0] !== 6'd0 || cap_data[0] !== 16'sd100 || done_cycle !== 4224) begin
            failures++;
            $display("FAIL abort_restart: idx=%0d data=%0d done=%0d, want 0 100 4224",
                     cap_idx[0], cap_data[0], done_cycle);
        end
    endtask

    task automatic test_start_while_busy();
        int bad;
        fill(128);
        run_block(-1, 0, 1);
        bad = 0;
        for (int i = 1; i < 64; i++) if (cap_data[i] !== 16'sd0 || cap_idx[i] !== 6'(i)) bad++;
        checks++;
        if (done_cycle !== 4224 || done_count !== 1 || cap_count !== 64) begin
            failures++;
            $display("FAIL restart_ignored: done=%0d count=%0d coefs=%0d, want 4224 1 64",
                     done_cycle, done_count, cap_count);
        end
        checks++;
        if (cap_data[0] !== FLAT128_DC || bad !== 0) begin
            failures++;
            $display("FAIL flat128: dc=%0d bad_ac=%0d, want %0d and 0", cap_data[0], bad, FLAT128_DC);
        end
    endtask

    task automatic test_saturation();
        int bad;
        fill(255);
        lut_force = 1;
        run_block(-1, 0, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (cap_data[i] !== 16'sd32767) bad++;
        checks++;
        if (bad !== 0 || cap_count !== 64) begin
            failures++;
            $display("FAIL sat_pos: %0d wrong (dc=%0d), want all 32767", bad, cap_data[0]);
        end
        lut_force = 2;
        run_block(-1, 0, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (cap_data[i] !== -16'sd32768) bad++;
        checks++;
        if (bad !== 0 || cap_count !== 64) begin
            failures++;
            $display("FAIL sat_neg: %0d wrong (dc=%0d), want all -32768", bad, cap_data[0]);
        end
        lut_force = 0;
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        bus.start      = 1'b0;
        bus.coef_ready = 1'b1;
        fill(0);
        test_reset();
        test_zero_block();
        test_single_pixel();
        test_ones();
        test_back_to_back_stall();
        test_reset_abort();
        test_start_while_busy();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
